// File: rtl/spb_pkg.sv
// Shared widths and FSM state encoding for the SPB address decoder.
package spb_pkg;
  localparam int SPB_ADDR_W = 32;
  localparam int SPB_DATA_W = 32;
  localparam int SPB_STB_W  = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} spb_dec_state_t;
endpackage

// File: rtl/spb_addr_match.sv
// Combinational base/mask window match with lowest-index priority.
module spb_addr_match
  import spb_pkg::*;
#(
  parameter int NUM_PORT = 4,
  parameter int SEL_W    = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
  input  logic [SPB_ADDR_W-1:0]          ADDR,
  input  logic [NUM_PORT*SPB_ADDR_W-1:0] BASE_ADDR,
  input  logic [NUM_PORT*SPB_ADDR_W-1:0] ADDR_MASK,
  output logic                           hit,
  output logic [SEL_W-1:0]               sel
);

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NUM_PORT - 1; i >= 0; i--) begin
      if ((ADDR & ADDR_MASK[SPB_ADDR_W*i +: SPB_ADDR_W]) ==
          (BASE_ADDR[SPB_ADDR_W*i +: SPB_ADDR_W] & ADDR_MASK[SPB_ADDR_W*i +: SPB_ADDR_W])) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/spb_decoder_n.sv
// 1-to-NUM_PORT SPB decoder: registered request, one-hot target select,
// local EXCPT termination for unmapped addresses and unresponsive targets.
module spb_decoder_n
  import spb_pkg::*;
#(
  parameter int NUM_PORT = 4,
  parameter logic [NUM_PORT*SPB_ADDR_W-1:0] BASE_ADDR =
    {32'h9000_0000, 32'h8000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_PORT*SPB_ADDR_W-1:0] ADDR_MASK = {NUM_PORT{32'hF000_0000}},
  parameter int TIMEOUT = 255
) (
  input  logic                           CLK,
  input  logic                           RST,
  // Handshake: initiator holds VALID until a one-cycle READY; targets see a
  // one-hot VALID held until their READY, and READY is only honoured in BUSY.
  input  logic                           S_SPB_VALID,
  output logic                           S_SPB_READY,
  input  logic [SPB_STB_W-1:0]           S_SPB_WSTB,
  input  logic [SPB_ADDR_W-1:0]          S_SPB_ADDR,
  input  logic [SPB_DATA_W-1:0]          S_SPB_WDATA,
  output logic [SPB_DATA_W-1:0]          S_SPB_RDATA,
  output logic                           S_SPB_EXCPT,
  output logic [NUM_PORT-1:0]            M_SPB_VALID,
  input  logic [NUM_PORT-1:0]            M_SPB_READY,
  output logic [NUM_PORT*SPB_STB_W-1:0]  M_SPB_WSTB,
  output logic [NUM_PORT*SPB_ADDR_W-1:0] M_SPB_ADDR,
  output logic [NUM_PORT*SPB_DATA_W-1:0] M_SPB_WDATA,
  input  logic [NUM_PORT*SPB_DATA_W-1:0] M_SPB_RDATA,
  input  logic [NUM_PORT-1:0]            M_SPB_EXCPT,
  output spb_dec_state_t                 dbg_state
);

  localparam int SEL_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  spb_dec_state_t        state;
  logic [SPB_ADDR_W-1:0] addr_r;
  logic [SPB_STB_W-1:0]  wstb_r;
  logic [SPB_DATA_W-1:0] wdata_r;
  logic [SEL_W-1:0]      sel_r;
  logic [TMR_W-1:0]      timer;
  logic [NUM_PORT-1:0]   m_valid_r;
  logic                  s_ready_r;
  logic [SPB_DATA_W-1:0] rdata_r;
  logic                  excpt_r;

  logic                  match_hit;
  logic [SEL_W-1:0]      match_sel;
  logic                  timeout_hit;

  spb_addr_match #(
    .NUM_PORT (NUM_PORT),
    .SEL_W    (SEL_W)
  ) u_match (
    .ADDR      (S_SPB_ADDR),
    .BASE_ADDR (BASE_ADDR),
    .ADDR_MASK (ADDR_MASK),
    .hit       (match_hit),
    .sel       (match_sel)
  );

  assign timeout_hit = (TIMEOUT != 0) && (timer == TMR_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      addr_r    <= '0;
      wstb_r    <= '0;
      wdata_r   <= '0;
      sel_r     <= '0;
      timer     <= '0;
      m_valid_r <= '0;
      s_ready_r <= 1'b0;
      rdata_r   <= '0;
      excpt_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (S_SPB_VALID) begin
            addr_r  <= S_SPB_ADDR;
            wstb_r  <= S_SPB_WSTB;
            wdata_r <= S_SPB_WDATA;
            sel_r   <= match_sel;
            timer   <= '0;
            if (match_hit) begin
              m_valid_r <= NUM_PORT'(1) << match_sel;
              state     <= BUSY;
            end else begin
              s_ready_r <= 1'b1;
              rdata_r   <= '0;
              excpt_r   <= 1'b1;
              state     <= RESP;
            end
          end
        end
        BUSY: begin
          if (timer != '1) timer <= timer + 1'b1;
          // A READY arriving on the last allowed cycle takes precedence over the timeout.
          if (M_SPB_READY[sel_r]) begin
            rdata_r   <= M_SPB_RDATA[SPB_DATA_W*sel_r +: SPB_DATA_W];
            excpt_r   <= M_SPB_EXCPT[sel_r];
            s_ready_r <= 1'b1;
            m_valid_r <= '0;
            state     <= RESP;
          end else if (timeout_hit) begin
            rdata_r   <= '0;
            excpt_r   <= 1'b1;
            s_ready_r <= 1'b1;
            m_valid_r <= '0;
            state     <= RESP;
          end
        end
        RESP: begin
          s_ready_r <= 1'b0;
          rdata_r   <= '0;
          excpt_r   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign S_SPB_READY = s_ready_r;
  assign S_SPB_RDATA = rdata_r;
  assign S_SPB_EXCPT = excpt_r;
  assign M_SPB_VALID = m_valid_r;
  assign M_SPB_WSTB  = {NUM_PORT{wstb_r}};
  assign M_SPB_ADDR  = {NUM_PORT{addr_r}};
  assign M_SPB_WDATA = {NUM_PORT{wdata_r}};
  assign dbg_state   = state;

endmodule

// File: tb/tb_spb_decoder_n.sv
// Randomized bench for spb_decoder_n against a window-table transaction model.
module tb_spb_decoder_n;
  import spb_pkg::*;

  localparam int NP = 4;
  localparam int TIMEOUT = 8;
  localparam int NEVER = 255;

  logic            clk;
  logic            rst;
  logic            s_valid;
  logic            s_ready;
  logic [3:0]      s_wstb;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [31:0]     s_rdata;
  logic            s_excpt;
  logic [NP-1:0]   m_valid;
  logic [NP-1:0]   m_ready;
  logic [NP*4-1:0] m_wstb;
  logic [NP*32-1:0] m_addr;
  logic [NP*32-1:0] m_wdata;
  logic [NP*32-1:0] m_rdata;
  logic [NP-1:0]   m_excpt;
  spb_dec_state_t  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  // Window table: port i owns the 256 MB region whose top nibble is win_nib[i].
  logic [3:0] win_nib [NP] = '{4'h0, 4'h1, 4'h8, 4'h9};
  logic [3:0] nib_pool [7] = '{4'h0, 4'h1, 4'h8, 4'h9, 4'h4, 4'hF, 4'h2};

  spb_decoder_n #(.NUM_PORT(NP), .TIMEOUT(TIMEOUT)) dut (
    .CLK(clk), .RST(rst),
    .S_SPB_VALID(s_valid), .S_SPB_READY(s_ready), .S_SPB_WSTB(s_wstb),
    .S_SPB_ADDR(s_addr), .S_SPB_WDATA(s_wdata), .S_SPB_RDATA(s_rdata),
    .S_SPB_EXCPT(s_excpt),
    .M_SPB_VALID(m_valid), .M_SPB_READY(m_ready), .M_SPB_WSTB(m_wstb),
    .M_SPB_ADDR(m_addr), .M_SPB_WDATA(m_wdata), .M_SPB_RDATA(m_rdata),
    .M_SPB_EXCPT(m_excpt),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int exp_port(input logic [31:0] a);
    for (int i = 0; i < NP; i++)
      if (a[31:28] == win_nib[i]) return i;
    return -1;
  endfunction

  // Random activity on every target input; the selected port's READY is kept low.
  task automatic drive_noise(input int p);
    m_ready = 4'($urandom_range(0, 15));
    m_excpt = 4'($urandom_range(0, 15));
    for (int i = 0; i < NP; i++) m_rdata[32*i +: 32] = $urandom;
    if (p >= 0) m_ready[p] = 1'b0;
  endtask

  // lat: BUSY cycles the target waits before READY (0 = first BUSY cycle).
  task automatic do_txn(input logic [31:0] addr, input logic [3:0] wstb,
                        input logic [31:0] wdata, input int lat,
                        input logic [31:0] t_rdata, input logic t_excpt);
    int p, cyc, vcnt, oh_err, bc_err, idle_err, exp_lat, exp_vcnt;
    logic got, g_excpt, e_excpt;
    logic [31:0] g_rdata, e_rdata;
    p = exp_port(addr);
    if (p < 0) begin
      exp_lat = 2; exp_vcnt = 0; e_rdata = 32'h0; e_excpt = 1'b1;
    end else if (lat < TIMEOUT) begin
      exp_lat = lat + 3; exp_vcnt = lat + 1; e_rdata = t_rdata; e_excpt = t_excpt;
    end else begin
      exp_lat = TIMEOUT + 2; exp_vcnt = TIMEOUT; e_rdata = 32'h0; e_excpt = 1'b1;
    end
    @(negedge clk);
    s_valid = 1'b1; s_addr = addr; s_wstb = wstb; s_wdata = wdata;
    cyc = 0; vcnt = 0; oh_err = 0; bc_err = 0; idle_err = 0; got = 1'b0;
    g_rdata = '0; g_excpt = 1'b0;
    while (!got && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      drive_noise(p);
      if (m_valid != '0) begin
        if (p < 0 || m_valid != (NP'(1) << p)) oh_err++;
        if (m_addr != {NP{addr}} || m_wstb != {NP{wstb}} || m_wdata != {NP{wdata}}) bc_err++;
        if (p >= 0 && vcnt == lat) begin
          m_ready[p] = 1'b1; m_rdata[32*p +: 32] = t_rdata; m_excpt[p] = t_excpt;
        end
        vcnt++;
      end
      if (s_ready) begin
        got = 1'b1; g_rdata = s_rdata; g_excpt = s_excpt;
      end else if (s_rdata != '0 || s_excpt) idle_err++;
    end
    s_valid = 1'b0;
    chk("resp_seen", 32'(got), 32'd1);
    chk("latency", 32'(cyc + 1), 32'(exp_lat));
    chk("rdata", g_rdata, e_rdata);
    chk("excpt", 32'(g_excpt), 32'(e_excpt));
    chk("valid_cycles", 32'(vcnt), 32'(exp_vcnt));
    chk("onehot_err", 32'(oh_err), 32'd0);
    chk("bcast_err", 32'(bc_err), 32'd0);
    chk("idle_resp_err", 32'(idle_err), 32'd0);
    @(posedge clk); #1;
    chk("ready_pulse", 32'(s_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_addr = '0; s_wstb = '0; s_wdata = '0;
    m_ready = '0; m_rdata = '0; m_excpt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_s_rdata", s_rdata, 32'd0);
    chk("rst_s_excpt", 32'(s_excpt), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_addr_or", 32'(|m_addr || |m_wdata || |m_wstb), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk); rst = 1'b0;

    do_txn(32'h1000_0010, 4'b0000, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    do_txn(32'h9000_0004, 4'b0011, 32'h1234_5678, 5, 32'h0, 1'b0);
    do_txn(32'h4000_0000, 4'b0000, 32'h0, 0, 32'h0, 1'b0);
    do_txn(32'h0000_0000, 4'b0000, 32'h0, NEVER, 32'h5555_5555, 1'b0);
    // Late READY from the timed-out target must not produce a response.
    for (int k = 0; k < 3; k++) begin
      m_ready = '1;
      @(posedge clk); #1;
      chk("late_ready", 32'(s_ready), 32'd0);
    end
    m_ready = '0;
    do_txn(32'h0000_0020, 4'b0000, 32'h0, TIMEOUT - 1, 32'h7777_0001, 1'b0);
    do_txn(32'h8000_0000, 4'b0000, 32'h0, 1, 32'hCAFE_0002, 1'b1);
    do_txn(32'h0000_0040, 4'b0000, 32'h0, 0, 32'hA5A5_0000, 1'b0);

    // Asynchronous reset in the middle of a BUSY transaction.
    @(negedge clk);
    s_valid = 1'b1; s_addr = 32'h0000_0100; s_wstb = 4'hF; s_wdata = 32'h1111_2222;
    m_ready = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_m_valid", 32'(m_valid), 32'd0);
    chk("arst_s_ready", 32'(s_ready), 32'd0);
    chk("arst_m_addr", m_addr[31:0], 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(IDLE));
    s_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    do_txn(32'h1000_0200, 4'b0000, 32'h0, 2, 32'h0BAD_F00D, 1'b0);

    for (int t = 0; t < 24; t++) begin
      logic [31:0] a;
      int l;
      a = {nib_pool[$urandom_range(0, 6)], 28'($urandom)};
      l = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, TIMEOUT + 2));
      do_txn(a, 4'($urandom_range(0, 15)), $urandom, l, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
